// File: rtl/emu_clk_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : emu_clk_sched_pkg
// Purpose  : Shared constants and types for the emulated-clock scheduler.
//            c_DT_WIDTH   - default width of time-step / half-period values
//            dt_t         - time-step type at the default width
//            c_EMU_TIME_W - width of the optional emulated-time accumulator
// Revision : 1.0 - initial release
// ============================================================================
package emu_clk_sched_pkg;

    localparam int c_DT_WIDTH   = 27;
    localparam int c_EMU_TIME_W = 64;

    typedef logic [c_DT_WIDTH-1:0] dt_t;

endpackage : emu_clk_sched_pkg
`default_nettype wire

// File: rtl/emu_dt_min.sv
`default_nettype none
// ============================================================================
// Module   : emu_dt_min
// Purpose  : Combinational minimum over N masked time values. Values whose
//            mask bit is clear are ignored; the result never exceeds DT_MAX,
//            which is also the result when no value is selected.
// Ports    : i_vals    - N packed values of W bits
//            i_mask    - per-value select
//            o_min_val - min(DT_MAX, selected values)
// Revision : 1.0 - initial release
// ============================================================================
module emu_dt_min
    import emu_clk_sched_pkg::*;
#(
    parameter int                N      = 2,
    parameter int                W      = c_DT_WIDTH,
    parameter logic [W-1:0]      DT_MAX = '1
) (
    input  logic [N-1:0][W-1:0]  i_vals,
    input  logic [N-1:0]         i_mask,
    output logic [W-1:0]         o_min_val
);

    always_comb begin
        o_min_val = DT_MAX;
        for (int k = 0; k < N; k++) begin
            if (i_mask[k] && (i_vals[k] < o_min_val)) begin
                o_min_val = i_vals[k];
            end
        end
    end

endmodule : emu_dt_min
`default_nettype wire

// File: rtl/emu_clk_sched.sv
`default_nettype none
// ============================================================================
// Module   : emu_clk_sched
// Purpose  : Emulated-clock scheduler. Each cycle advances emulated time by
//            the largest step that does not skip over any enabled channel's
//            next edge, and toggles every channel whose edge lands exactly
//            on that step.
// Ports    : emu_clk     - emulator clock (all state on posedge)
//            emu_rst     - synchronous active-high reset
//            half_period - per-channel half period, 0 treated as 1
//            chan_en     - per-channel enable (disabled channel is frozen)
//            stall       - hold emulated time for this cycle
//            clk_vals    - registered next clock level per channel
//            emu_dt      - registered time step applied this cycle
//            emu_time    - running sum of emu_dt (only with macro
//                          EMU_CLK_SCHED_TIME_EN defined)
// Revision : 1.0 - initial release
// ============================================================================
module emu_clk_sched
    import emu_clk_sched_pkg::*;
#(
    parameter int                  N        = 2,
    parameter int                  DT_WIDTH = c_DT_WIDTH,
    parameter logic [DT_WIDTH-1:0] DT_MAX   = '1
) (
    input  logic                         emu_clk,
    input  logic                         emu_rst,
    input  logic [N-1:0][DT_WIDTH-1:0]   half_period,
    input  logic [N-1:0]                 chan_en,
    input  logic                         stall,
    output logic [N-1:0]                 clk_vals,
    output logic [DT_WIDTH-1:0]          emu_dt
`ifdef EMU_CLK_SCHED_TIME_EN
    ,
    output logic [c_EMU_TIME_W-1:0]      emu_time
`endif
);

    logic [N-1:0][DT_WIDTH-1:0] r_rem;
    logic [N-1:0][DT_WIDTH-1:0] w_reload;
    logic [N-1:0]               r_clk_vals;
    logic [DT_WIDTH-1:0]        r_emu_dt;
    logic [DT_WIDTH-1:0]        w_dt;

    // A zero half period would make rem 0 and stall time forever; clamp to 1.
    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_reload
            assign w_reload[g] = (half_period[g] == '0) ? DT_WIDTH'(1)
                                                        : half_period[g];
        end
    endgenerate

    // The step is the nearest pending edge, so rem - dt can never underflow.
    emu_dt_min #(
        .N      (N),
        .W      (DT_WIDTH),
        .DT_MAX (DT_MAX)
    ) u_dt_min (
        .i_vals    (r_rem),
        .i_mask    (chan_en),
        .o_min_val (w_dt)
    );

    always_ff @(posedge emu_clk) begin
        if (emu_rst) begin
            r_rem      <= w_reload;
            r_clk_vals <= '0;
            r_emu_dt   <= '0;
        end else if (stall) begin
            r_emu_dt   <= '0;
        end else begin
            r_emu_dt <= w_dt;
            for (int k = 0; k < N; k++) begin
                if (chan_en[k]) begin
                    if (r_rem[k] == w_dt) begin
                        r_clk_vals[k] <= ~r_clk_vals[k];
                        r_rem[k]      <= w_reload[k];
                    end else begin
                        r_rem[k]      <= r_rem[k] - w_dt;
                    end
                end
            end
        end
    end

    assign clk_vals = r_clk_vals;
    assign emu_dt   = r_emu_dt;

`ifdef EMU_CLK_SCHED_TIME_EN
    // Accumulate the step being issued on this edge so emu_time always equals
    // the sum of every emu_dt value presented so far.
    logic [c_EMU_TIME_W-1:0] r_emu_time;

    always_ff @(posedge emu_clk) begin
        if (emu_rst) begin
            r_emu_time <= '0;
        end else if (!stall) begin
            r_emu_time <= r_emu_time + c_EMU_TIME_W'(w_dt);
        end
    end

    assign emu_time = r_emu_time;
`endif

endmodule : emu_clk_sched
`default_nettype wire

// File: tb/tb_emu_clk_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_emu_clk_sched
// Purpose  : Directed self-checking bench for emu_clk_sched (N=2,
//            DT_MAX=100). Expected step and clock-level sequences are
//            hand-computed from the scheduling rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_emu_clk_sched;

    localparam int c_N  = 2;
    localparam int c_W  = 27;

    logic                     emu_clk;
    logic                     emu_rst;
    logic [c_N-1:0][c_W-1:0]  half_period;
    logic [c_N-1:0]           chan_en;
    logic                     stall;
    logic [c_N-1:0]           clk_vals;
    logic [c_W-1:0]           emu_dt;
`ifdef EMU_CLK_SCHED_TIME_EN
    logic [63:0]              emu_time;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    emu_clk_sched #(
        .N        (c_N),
        .DT_WIDTH (c_W),
        .DT_MAX   (c_W'(100))
    ) dut (
        .emu_clk     (emu_clk),
        .emu_rst     (emu_rst),
        .half_period (half_period),
        .chan_en     (chan_en),
        .stall       (stall),
        .clk_vals    (clk_vals),
        .emu_dt      (emu_dt)
`ifdef EMU_CLK_SCHED_TIME_EN
        ,
        .emu_time    (emu_time)
`endif
    );

    initial emu_clk = 1'b0;
    always #5 emu_clk = ~emu_clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one emu_clk edge and check the registered outputs 1 time unit later.
    task automatic step(input string tag, input int exp_dt, input logic [1:0] exp_cv);
        @(posedge emu_clk);
        #1;
        check({tag, " dt"}, longint'(emu_dt), longint'(exp_dt));
        check({tag, " cv"}, longint'(clk_vals), longint'(exp_cv));
    endtask

    task automatic set_hp(input int hp0, input int hp1);
        half_period[0] = c_W'(hp0);
        half_period[1] = c_W'(hp1);
    endtask

    initial begin
        // Reset ignores stall and chan_en.
        emu_rst = 1'b1;
        stall   = 1'b1;
        chan_en = 2'b00;
        set_hp(5, 3);
        step("rst", 0, 2'b00);
        step("rst2", 0, 2'b00);
`ifdef EMU_CLK_SCHED_TIME_EN
        check("rst time", longint'(emu_time), 0);
`endif
        emu_rst = 1'b0;
        stall   = 1'b0;
        chan_en = 2'b11;

        // hp={5,3}: edges at t=3,5,6,9,10
        step("a1", 3, 2'b10);
        step("a2", 2, 2'b11);
        step("a3", 1, 2'b01);
        step("a4", 3, 2'b11);
`ifdef EMU_CLK_SCHED_TIME_EN
        check("a4 time", longint'(emu_time), 9);
`endif

        // Mid-run reset discards pending time.
        emu_rst = 1'b1;
        step("mrst", 0, 2'b00);
`ifdef EMU_CLK_SCHED_TIME_EN
        check("mrst time", longint'(emu_time), 0);
`endif
        emu_rst = 1'b0;
        step("b1", 3, 2'b10);
        step("b2", 2, 2'b11);

        // Stall for 3 cycles: dt 0, everything held.
        stall = 1'b1;
        step("st1", 0, 2'b11);
        step("st2", 0, 2'b11);
        step("st3", 0, 2'b11);
        stall = 1'b0;
        step("b3", 1, 2'b01);
        step("b4", 3, 2'b11);
        step("b5", 1, 2'b10);
        step("b6", 2, 2'b00);
        step("b7", 3, 2'b11);
`ifdef EMU_CLK_SCHED_TIME_EN
        check("b7 time", longint'(emu_time), 15);
`endif

        // hp={4,4}: simultaneous edges every step.
        emu_rst = 1'b1;
        set_hp(4, 4);
        step("c rst", 0, 2'b00);
        emu_rst = 1'b0;
        step("c1", 4, 2'b11);
        step("c2", 4, 2'b00);
        step("c3", 4, 2'b11);

        // hp={2,7}: run to rem0=1, then disable channel 0.
        emu_rst = 1'b1;
        set_hp(2, 7);
        step("d rst", 0, 2'b00);
        emu_rst = 1'b0;
        step("d1", 2, 2'b01);
        step("d2", 2, 2'b00);
        step("d3", 2, 2'b01);
        step("d4", 1, 2'b11);
        chan_en = 2'b10;
        step("d5", 7, 2'b01);
        step("d6", 7, 2'b11);
        chan_en = 2'b11;
        step("d7", 1, 2'b10);
        step("d8", 2, 2'b11);

        // No channel enabled: DT_MAX; then hp0=0 gives a toggle every cycle.
        emu_rst = 1'b1;
        set_hp(0, 7);
        step("e rst", 0, 2'b00);
        emu_rst = 1'b0;
        chan_en = 2'b00;
        step("e1", 100, 2'b00);
        step("e2", 100, 2'b00);
        chan_en = 2'b01;
        step("e3", 1, 2'b01);
        step("e4", 1, 2'b00);
        step("e5", 1, 2'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_emu_clk_sched
`default_nettype wire
